// File: rtl/text_pixel_gen_pkg.sv
// Shared constants and types for the text-mode pixel generator.
package hdmi_text_pkg;

  localparam logic [9:0]  H_ACTIVE = 10'd640;
  localparam logic [9:0]  V_ACTIVE = 10'd480;
  localparam logic [6:0]  COLS     = 7'd80;
  localparam logic [4:0]  ROWS     = 5'd30;
  localparam logic [10:0] WORDS    = 11'd1200;
  localparam logic [3:0]  CHAR_W   = 4'd8;
  localparam logic [4:0]  CHAR_H   = 5'd16;

  // One character cell as stored in each VRAM half-word.
  typedef struct packed {
    logic       invert;
    logic [6:0] code;
    logic [3:0] fg;
    logic [3:0] bg;
  } char_attr_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Word address of the cell pair under (x, y): row*40 + col/2, with
  // the multiply built from shifts so it maps onto two adders.
  function automatic logic [10:0] text_word_addr(input logic [9:0] x,
                                                 input logic [9:0] y);
    logic [10:0] row;
    logic [10:0] pair;
    row  = {5'd0, y[9:4]};
    pair = {5'd0, x[9:4]};
    return (row << 5) + (row << 3) + pair;
  endfunction

  // Pick one 12-bit {R,G,B} entry out of the flattened 16-entry palette.
  function automatic rgb12_t palette_lookup(input logic [191:0] pal,
                                            input logic [3:0]   idx);
    rgb12_t res;
    res = 12'h000;
    for (int i = 0; i < 16; i++) begin
      res = (idx == i[3:0]) ? rgb12_t'(pal[i*12 +: 12]) : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/text_pixel_gen_if.sv
// Memory-side bus of the pixel generator: VRAM display port and font ROM.
// Both memories answer one clock after the address is presented.
interface text_pixel_gen_if;

  logic [10:0] vram_addr;
  logic [31:0] vram_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;

  modport master (
    output vram_addr,
    output font_addr,
    input  vram_data,
    input  font_data
  );

  modport slave (
    input  vram_addr,
    input  font_addr,
    output vram_data,
    output font_data
  );

endinterface

// File: rtl/text_pixel_gen_sync_delay.sv
// N-stage shift register that keeps syncs/data-enable aligned with the
// pixel pipeline. Stage 0 holds the newest sample.
module sync_delay #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] stage_r;

  // Shift the sync vector one stage per pixel clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_r <= '0;
    end else begin
      stage_r <= {stage_r[N-2:0], d};
    end
  end

  assign q = stage_r[N-1];

endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: raster position -> VRAM word -> glyph row ->
// palette colour, as a fixed four-register pipeline with no stalls.
module text_pixel_gen
  import hdmi_text_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              drawX,
  input  logic [9:0]              drawY,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    vde_in,
  text_pixel_gen_if.master        mem,
  input  logic [191:0]            palette,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    vde
);

  // S0: registered address and position
  logic        in_range_s;
  logic [10:0] vram_addr_r;
  logic [3:0]  s0_x_r;
  logic [3:0]  s0_row_r;
  logic        s0_vis_r;

  // S1: VRAM data is on the bus
  logic [3:0]  s1_x_r;
  logic [3:0]  s1_row_r;
  logic        s1_vis_r;
  logic        s1_live_r;
  char_attr_t  s1_char_s;
  logic [10:0] font_addr_s;

  // S2: glyph row is on the bus
  logic        s2_invert_r;
  logic [3:0]  s2_fg_r;
  logic [3:0]  s2_bg_r;
  logic [2:0]  s2_x_r;
  logic        s2_vis_r;
  logic        pix_s;
  logic [3:0]  idx_s;
  rgb12_t      colour_s;

  // S3: output register
  rgb12_t      rgb_r;
  logic [2:0]  sync_q_s;

  assign in_range_s = (drawX < H_ACTIVE) && (drawY < V_ACTIVE);

  // S0: sample the raster position; off-screen positions read word 0 so
  // the address can never run past the end of VRAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vram_addr_r <= 11'd0;
      s0_x_r      <= 4'd0;
      s0_row_r    <= 4'd0;
      s0_vis_r    <= 1'b0;
    end else begin
      vram_addr_r <= in_range_s ? text_word_addr(drawX, drawY) : 11'd0;
      s0_x_r      <= drawX[3:0];
      s0_row_r    <= drawY[3:0];
      s0_vis_r    <= in_range_s & vde_in;
    end
  end

  assign mem.vram_addr = vram_addr_r;

  // S1: carry position alongside the VRAM read; live flags that S1 holds
  // a sample taken after reset, so font_addr stays 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_x_r    <= 4'd0;
      s1_row_r  <= 4'd0;
      s1_vis_r  <= 1'b0;
      s1_live_r <= 1'b0;
    end else begin
      s1_x_r    <= s0_x_r;
      s1_row_r  <= s0_row_r;
      s1_vis_r  <= s0_vis_r;
      s1_live_r <= 1'b1;
    end
  end

  // S1: choose the even/odd cell of the word and form the glyph address.
  always_comb begin
    s1_char_s   = s1_x_r[3] ? char_attr_t'(mem.vram_data[31:16])
                            : char_attr_t'(mem.vram_data[15:0]);
    font_addr_s = s1_live_r ? {s1_char_s.code, s1_row_r} : 11'd0;
  end

  assign mem.font_addr = font_addr_s;

  // S2: hold the cell attributes while the font ROM answers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_invert_r <= 1'b0;
      s2_fg_r     <= 4'd0;
      s2_bg_r     <= 4'd0;
      s2_x_r      <= 3'd0;
      s2_vis_r    <= 1'b0;
    end else begin
      s2_invert_r <= s1_char_s.invert;
      s2_fg_r     <= s1_char_s.fg;
      s2_bg_r     <= s1_char_s.bg;
      s2_x_r      <= s1_x_r[2:0];
      s2_vis_r    <= s1_vis_r;
    end
  end

  // S2: pick the glyph bit (bit 7 is leftmost) and resolve the colour
  // from the live palette, so palette writes show on the next pixel.
  always_comb begin
    pix_s    = mem.font_data[3'd7 - s2_x_r] ^ s2_invert_r;
    idx_s    = pix_s ? s2_fg_r : s2_bg_r;
    colour_s = palette_lookup(palette, idx_s);
  end

  // S3: register the pixel colour, black outside the visible area.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_r <= 12'h000;
    end else begin
      rgb_r <= s2_vis_r ? colour_s : 12'h000;
    end
  end

  assign red   = rgb_r.r;
  assign green = rgb_r.g;
  assign blue  = rgb_r.b;

  sync_delay #(
    .N(4),
    .W(3)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .d   ({hsync_in, vsync_in, vde_in}),
    .q   (sync_q_s)
  );

  assign {hsync, vsync, vde} = sync_q_s;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen with behavioural VRAM and font ROM.
module tb_text_pixel_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   drawX;
  logic [9:0]   drawY;
  logic         hsync_in;
  logic         vsync_in;
  logic         vde_in;
  logic [191:0] palette;
  logic [3:0]   red;
  logic [3:0]   green;
  logic [3:0]   blue;
  logic         hsync;
  logic         vsync;
  logic         vde;

  text_pixel_gen_if mem_if ();

  text_pixel_gen dut (
    .clk      (clk),
    .rst      (rst),
    .drawX    (drawX),
    .drawY    (drawY),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .vde_in   (vde_in),
    .mem      (mem_if),
    .palette  (palette),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .hsync    (hsync),
    .vsync    (vsync),
    .vde      (vde)
  );

  always #5 clk = ~clk;

  logic [31:0] vram [0:1199];
  logic [7:0]  font_rom [0:2047];

  // Synchronous-read memories: data one clock after the address.
  always @(posedge clk) begin
    mem_if.vram_data <= (mem_if.vram_addr < 11'd1200) ? vram[mem_if.vram_addr] : 32'hDEAD_BEEF;
    mem_if.font_data <= font_rom[mem_if.font_addr];
  end

  int tests = 0;
  int fails = 0;

  logic [9:0]  vx [8];
  logic [9:0]  vy [8];
  logic        vh [8];
  logic        vv [8];
  logic        vd [8];
  logic [10:0] e_addr [8];
  logic [10:0] e_font [8];
  logic        chk_f [8];
  logic [11:0] e_rgb [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [9:0] x, input logic [9:0] y,
                       input logic h, input logic v, input logic de);
    drawX    = x;
    drawY    = y;
    hsync_in = h;
    vsync_in = v;
    vde_in   = de;
  endtask

  task automatic set_vec(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic h, input logic v, input logic de,
                         input logic [10:0] a, input logic [10:0] f, input logic cf,
                         input logic [11:0] c);
    vx[i] = x; vy[i] = y; vh[i] = h; vv[i] = v; vd[i] = de;
    e_addr[i] = a; e_font[i] = f; chk_f[i] = cf; e_rgb[i] = c;
  endtask

  // Pixels 0..7 of text cell (0,0) on line 0, fg colour on pixels 3-4.
  task automatic load_cell0(input logic [11:0] fgc, input logic [11:0] bgc, input logic [11:0] fgc4);
    for (int i = 0; i < 8; i++) begin
      set_vec(i, 10'(i), 10'd0, i[0], (i == 2), 1'b1, 11'd0, 11'h410, 1'b1,
              (i == 3) ? fgc : ((i == 4) ? fgc4 : bgc));
    end
  endtask

  // Stream n vectors back to back; outputs of vector k show after the
  // edge that also samples vector k+3.
  task automatic run_stream(input string tag, input int n, input int pal_step,
                            input logic [11:0] pal_val);
    for (int k = 0; k < n + 3; k++) begin
      if (k < n) drive(vx[k], vy[k], vh[k], vv[k], vd[k]);
      else       drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      if (k < n)
        check($sformatf("%s vram_addr[%0d]", tag, k), 32'(mem_if.vram_addr), 32'(e_addr[k]));
      if (k >= 1 && k <= n && chk_f[k-1])
        check($sformatf("%s font_addr[%0d]", tag, k-1), 32'(mem_if.font_addr), 32'(e_font[k-1]));
      if (k >= 3) begin
        check($sformatf("%s rgb[%0d]", tag, k-3), 32'({red, green, blue}), 32'(e_rgb[k-3]));
        check($sformatf("%s hsync[%0d]", tag, k-3), 32'(hsync), 32'(vh[k-3]));
        check($sformatf("%s vsync[%0d]", tag, k-3), 32'(vsync), 32'(vv[k-3]));
        check($sformatf("%s vde[%0d]", tag, k-3), 32'(vde), 32'(vd[k-3]));
      end
      if (k == pal_step) palette[24 +: 12] = pal_val;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " vram_addr"}, 32'(mem_if.vram_addr), 32'd0);
    check({tag, " font_addr"}, 32'(mem_if.font_addr), 32'd0);
    check({tag, " rgb"}, 32'({red, green, blue}), 32'd0);
    check({tag, " syncs"}, 32'({hsync, vsync, vde}), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1200; i++) vram[i] = 32'h0;
    for (int i = 0; i < 2048; i++) font_rom[i] = 8'h00;
    vram[0]    = 32'h0000_412F;
    vram[252]  = 32'h0000_7F11;
    vram[1199] = 32'h5A34_0000;
    font_rom[11'h410] = 8'h18;
    for (int r = 0; r < 16; r++) font_rom[11'h5A0 + r] = 8'hF0;
    font_rom[11'h5A7] = 8'h08;
    palette = 192'd0;
    palette[0*12 +: 12]  = 12'hABC;
    palette[2*12 +: 12]  = 12'hF00;
    palette[3*12 +: 12]  = 12'h123;
    palette[4*12 +: 12]  = 12'h456;
    palette[15*12 +: 12] = 12'h00F;

    // Reset state
    rst = 1'b0;
    drive(10'd3, 10'd0, 1'b1, 1'b1, 1'b1);
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Cell 0 normal, then inverted
    load_cell0(12'hF00, 12'h00F, 12'hF00);
    run_stream("normal", 8, -1, 12'h000);
    vram[0] = 32'h0000_C12F;
    load_cell0(12'h00F, 12'hF00, 12'h00F);
    run_stream("invert", 8, -1, 12'h000);
    vram[0] = 32'h0000_412F;

    // Last cell of the screen, upper half-word, and a mid-screen cell
    set_vec(0, 10'd632, 10'd464, 1'b1, 1'b0, 1'b1, 11'd1199, 11'h5A0, 1'b1, 12'h123);
    set_vec(1, 10'd639, 10'd479, 1'b0, 1'b1, 1'b1, 11'd1199, 11'h5AF, 1'b1, 12'h456);
    set_vec(2, 10'd636, 10'd471, 1'b1, 1'b1, 1'b1, 11'd1199, 11'h5A7, 1'b1, 12'h123);
    set_vec(3, 10'd635, 10'd475, 1'b0, 1'b0, 1'b1, 11'd1199, 11'h5AB, 1'b1, 12'h123);
    set_vec(4, 10'd200, 10'd100, 1'b1, 1'b1, 1'b1, 11'd252,  11'h004, 1'b1, 12'hABC);
    run_stream("corner", 5, -1, 12'h000);

    // Blanking: off-screen and vde low
    set_vec(0, 10'd700, 10'd0,   1'b1, 1'b0, 1'b1, 11'd0,    11'h000, 1'b0, 12'h000);
    set_vec(1, 10'd0,   10'd500, 1'b0, 1'b1, 1'b1, 11'd0,    11'h000, 1'b0, 12'h000);
    set_vec(2, 10'd640, 10'd0,   1'b1, 1'b1, 1'b1, 11'd0,    11'h000, 1'b0, 12'h000);
    set_vec(3, 10'd0,   10'd480, 1'b0, 1'b0, 1'b1, 11'd0,    11'h000, 1'b0, 12'h000);
    set_vec(4, 10'd16,  10'd16,  1'b1, 1'b0, 1'b0, 11'd41,   11'h000, 1'b0, 12'h000);
    set_vec(5, 10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 11'd1199, 11'h5AF, 1'b1, 12'h456);
    run_stream("blank", 6, -1, 12'h000);

    // Reset asserted mid-line
    drive(10'd3, 10'd0, 1'b1, 1'b1, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("pre-reset rgb", 32'({red, green, blue}), 32'h0F00);
    check("pre-reset font_addr", 32'(mem_if.font_addr), 32'h410);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid-reset");
    @(posedge clk); #1;
    rst = 1'b1;
    drive(10'd3, 10'd0, 1'b1, 1'b1, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      if (e < 4) begin
        check($sformatf("refill rgb edge%0d", e), 32'({red, green, blue}), 32'd0);
        check($sformatf("refill syncs edge%0d", e), 32'({hsync, vsync, vde}), 32'd0);
      end else begin
        check("refill rgb edge4", 32'({red, green, blue}), 32'h0F00);
        check("refill syncs edge4", 32'({hsync, vsync, vde}), 32'b111);
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
    end

    // Palette entry 2 rewritten right after pixel 3 leaves the pipe
    load_cell0(12'hF00, 12'h00F, 12'h0F0);
    run_stream("palette", 8, 6, 12'h0F0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/text_pixel_gen.md
Name: text_pixel_gen

Overview:
Display-side consumer of the text VRAM. Converts the raster position from the VGA timing generator into VRAM read addresses, fetches glyph rows from the font ROM, and applies per-character palette colours. Output is registered 4-bit RGB plus delay-matched hsync/vsync/vde, which drive the HDMI encoder. The block is a fixed-latency pipeline that follows the synchronous-read timing of the VRAM display port and of the font ROM.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- COLS, 80, text columns (8-pixel-wide glyphs)
- ROWS, 30, text rows (16-pixel-tall glyphs)
- WORDS, 1200, VRAM depth (COLS*ROWS/2)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- drawX  in  10  current pixel column from the timing generator
- drawY  in  10  current pixel line from the timing generator
- hsync_in, vsync_in, vde_in  in  1 each  timing-generator syncs and data-enable
- vram_addr  out  11  word address to the VRAM display read port
- vram_data  in  32  VRAM display read data, valid 1 cycle after vram_addr
- font_addr  out  11  {code[6:0], glyph_row[3:0]} to the font ROM
- font_data  in  8  glyph row from the font ROM, valid 1 cycle after font_addr; bit 7 is the leftmost pixel
- palette  in  192  16 entries x 12 bits; entry i is at [12i+11:12i] = {R,G,B} 4 bits each
- red, green, blue  out  4 each  pixel colour
- hsync, vsync, vde  out  1 each  delay-matched syncs and data-enable

Behaviour:
- Character format (16 bits): [15] invert, [14:8] code, [7:4] fg index, [3:0] bg index. Word bits [15:0] hold the even column; bits [31:16] hold the odd column.
- S0 (registered inputs): capture drawX, drawY, hsync_in, vsync_in, vde_in.
- S0 address generation: col = drawX>>3, row = drawY>>4, vram_addr = row*40 + (col>>1). The multiply is done as (row<<5)+(row<<3) and is 11 bits wide.
- Out-of-range positions (drawX >= H_ACTIVE or drawY >= V_ACTIVE): vram_addr is forced to 0, so the address never exceeds WORDS-1, and the pixel is marked blank.
- S1: vram_data is valid. Select the half-word with col[0]. Drive font_addr = {code, drawY[3:0]}. Carry the invert flag, fg, bg, drawX[2:0], blank, and syncs forward.
- S2: font_data is valid. pix = font_data[7 - x[2:0]] XOR invert. idx = pix ? fg : bg. Look up the palette combinationally.
- S3 (output registers): {red,green,blue} = palette[idx], or 12'h000 if blank or vde is low. hsync, vsync and vde are the S2 copies.
- Latency: inputs sampled at clock edge t appear on outputs after edge t+3. All outputs are skewed identically, with no gaps, bubbles or stalls.
- Palette changes take effect on the next pixel. No shadowing.
- Reset (rst low, asynchronous): all pipeline registers, vram_addr, font_addr, RGB, hsync, vsync and vde go to 0 immediately.
- Reset release: output is valid from the 4th edge onward. Reset mid-frame causes no corruption beyond the refill.
- Simultaneous events: a VRAM write to the word being read returns the value the VRAM presents on its port. This block adds no hazard handling.

Decomposition:
- Package hdmi_text_pkg holds:
  - the constants H_ACTIVE, V_ACTIVE, COLS, ROWS, WORDS, CHAR_W=8, CHAR_H=16
  - the packed struct char_attr_t {invert, code[6:0], fg[3:0], bg[3:0]}
  - the typedef rgb12_t
- One sub-module, sync_delay (an N-stage shift register for hsync/vsync/vde, with async active-low reset), instantiated with N=4. The font ROM stays external.

Test Plan:
- VRAM word 0 = 32'h0000_412F, font row {0x41,0} = 8'h18, palette[2] = 12'hF00, palette[15] = 12'h00F, drawY=0, drawX=0..7 with vde=1:
  - vram_addr = 0 and font_addr = 11'h410
  - outputs 4 cycles later: pixels 0-2 and 5-7 = 00F, pixels 3-4 = F00
- Same character with bit 15 set (word 32'h0000_C12F): the colours from the first scenario are swapped at each pixel.
- drawX=632..639, drawY=464..479: vram_addr = 1199, upper half-word selected, font_addr row = drawY[3:0].
- Blanking: drawX=700 or drawY=500 with vde=1, and vde=0 in active area:
  - vram_addr = 0 and RGB = 000
  - hsync/vsync follow the inputs delayed exactly 4 cycles
- Assert rst low mid-line: all outputs 0 asynchronously, in the same cycle. On release, the first correct pixel appears after 4 edges, and sync alignment matches the inputs.
- Palette change: write palette[2] = 12'h0F0 mid-line; subsequent fg pixels change to 0F0 starting on the next pixel, with no glitch on the others.
